// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle arithmetic/logic ops, shifts done one bit per
// clock. Valid/ready handshake on both sides; one operation in flight.
module iter_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned SW = $clog2(XLEN);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SRA  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  logic [1:0]      state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;

  logic            accept;
  logic            is_shift;
  logic            legal;
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] imm_res;
  logic [XLEN-1:0] step_res;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
  assign accept    = in_valid && in_ready;
  assign shamt     = src_b[SW-1:0];

  // Decode the requested operation and compute the single-cycle result.
  always_comb begin
    alu_res  = '0;
    is_shift = 1'b0;
    legal    = 1'b1;
    case (ALUControl)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
      default: legal = 1'b0;
    endcase
    // A zero-distance shift completes like any other single-cycle op
    imm_res = is_shift ? src_a : alu_res;
  end

  // One-bit shift of the work register according to the latched opcode.
  always_comb begin
    case (op_q)
      OP_SLL:  step_res = {work_q[XLEN-2:0], 1'b0};
      OP_SRL:  step_res = {1'b0, work_q[XLEN-1:1]};
      default: step_res = {work_q[XLEN-1], work_q[XLEN-1:1]};
    endcase
  end

  // Next-state logic for the control FSM and datapath registers.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = ALUControl;
          if (is_shift && (shamt != '0)) begin
            work_d  = src_a;
            cnt_d   = shamt;
            state_d = SHIFT;
          end else begin
            result_d  = imm_res;
            zero_d    = (imm_res == '0);
            illegal_d = ~legal;
            state_d   = DONE;
          end
        end
      end
      SHIFT: begin
        work_d = step_res;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          result_d  = step_res;
          zero_d    = (step_res == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; synchronous reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      work_q    <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
